// File: rtl/param_demux_reg_if.sv
// rtl/param_demux_reg_if.sv - producer/consumer bus bundle for the registered 1-to-DEPTH demux
interface param_demux_reg_if #(
    parameter int DEPTH     = 8,
    parameter int WORD_SIZE = 8,
    parameter int CNT_W     = 16
);
    localparam int SEL_W = $clog2(DEPTH);

    logic                 i_valid;
    logic                 o_ready;
    logic [SEL_W-1:0]     i_select;
    logic [WORD_SIZE-1:0] i_data;
    logic [WORD_SIZE-1:0] o_out [DEPTH-1:0];
    logic [DEPTH-1:0]     o_valid;
    logic [DEPTH-1:0]     i_ready;
    logic [CNT_W-1:0]     o_drop_count;
    logic [CNT_W-1:0]     o_xfer_count;

    modport master (
        output i_valid, i_select, i_data, i_ready,
        input  o_ready, o_out, o_valid, o_drop_count, o_xfer_count
    );

    modport slave (
        input  i_valid, i_select, i_data, i_ready,
        output o_ready, o_out, o_valid, o_drop_count, o_xfer_count
    );
endinterface

// File: rtl/param_demux_reg.sv
// rtl/param_demux_reg.sv - registered 1-to-DEPTH demux with per-channel holding registers; PARAM_DEMUX_STATS_EN enables o_xfer_count
module param_demux_reg #(
    parameter int DEPTH     = 8,
    parameter int WORD_SIZE = 8,
    parameter int CNT_W     = 16
) (
    input logic              i_clk,
    input logic              i_rst,
    param_demux_reg_if.slave bus
);
    localparam int SEL_W = $clog2(DEPTH);

    logic [DEPTH-1:0]     full;
    logic [WORD_SIZE-1:0] data_q [DEPTH-1:0];
    logic [CNT_W-1:0]     drop_q;

    logic                 in_range;
    logic                 sel_full;
    logic                 sel_rdy;
    logic                 ready;
    logic                 accept;
    logic [DEPTH-1:0]     load;

    // Decode the select: range check and the selected channel's occupancy/ready.
    // A loop compare avoids indexing past DEPTH when DEPTH is not a power of 2.
    always_comb begin
        in_range = 1'b0;
        sel_full = 1'b0;
        sel_rdy  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (bus.i_select == SEL_W'(k)) begin
                in_range = 1'b1;
                sel_full = full[k];
                sel_rdy  = bus.i_ready[k];
            end
        end
        // Out-of-range words are always taken (and dropped); an in-range channel
        // can take a word if empty or if it drains in the same cycle.
        ready  = !in_range || !sel_full || sel_rdy;
        accept = bus.i_valid && ready;
    end

    // One-hot load strobe for the channel receiving the accepted word.
    always_comb begin
        load = '0;
        for (int k = 0; k < DEPTH; k++) begin
            load[k] = accept && (bus.i_select == SEL_W'(k));
        end
    end

    // Per-channel holding registers: load wins over drain, data kept after drain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (load[k]) begin
                    data_q[k] <= bus.i_data;
                    full[k]   <= 1'b1;
                end else if (full[k] && bus.i_ready[k]) begin
                    full[k]   <= 1'b0;
                end
            end
        end
    end

    // Saturating count of words discarded for an out-of-range select.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_q <= '0;
        end else if (accept && !in_range && (drop_q != '1)) begin
            drop_q <= drop_q + CNT_W'(1);
        end
    end

`ifdef PARAM_DEMUX_STATS_EN
    logic [CNT_W-1:0] xfer_q;

    // Saturating count of words delivered into a channel.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            xfer_q <= '0;
        end else if (accept && in_range && (xfer_q != '1)) begin
            xfer_q <= xfer_q + CNT_W'(1);
        end
    end

    assign bus.o_xfer_count = xfer_q;
`else
    assign bus.o_xfer_count = '0;
`endif

    assign bus.o_ready      = ready;
    assign bus.o_valid      = full;
    assign bus.o_out        = data_q;
    assign bus.o_drop_count = drop_q;
endmodule
